button_cmd_gen: RTL and testbench



---
 rtl/button_cmd_gen.sv | 118 +++++++++++
 tb/tb_button_cmd_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_gen.sv
// -----------------------------------------------------------------------------
// button_cmd_gen
//
// Turns three raw, asynchronous, bouncing push-button levels into clean
// single-cycle command pulses for the stopwatch control FSM.
//
// Per channel: two-flop synchroniser -> debounce counter -> rising-edge detect.
// A fixed-priority arbiter (reset > stop > start) guarantees at most one
// command pulse per cycle. Losing pulses are dropped, not queued.
//
// Handshake: none. Outputs are plain registered pulses. start/stop/reset are
// high for exactly one cycle per debounced press and are one-hot-or-zero.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_start_raw  in   raw start button, active-high, async to clk
//   btn_stop_raw   in   raw stop button, active-high, async to clk
//   btn_reset_raw  in   raw reset button, active-high, async to clk
//   start          out  one-cycle command pulse to FSM start
//   stop           out  one-cycle command pulse to FSM stop
//   reset          out  one-cycle command pulse to FSM reset
//   btn_level      out  debounced levels {reset, stop, start}
// -----------------------------------------------------------------------------
module button_cmd_gen #(
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_raw,
    input  logic       btn_stop_raw,
    input  logic       btn_reset_raw,
    output logic       start,
    output logic       stop,
    output logic       reset,
    output logic [2:0] btn_level
);

    // Channel index order everywhere: [2]=reset, [1]=stop, [0]=start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]            raw;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [2:0]            level_q;
    logic [2:0]            level_d;
    logic [2:0][CNT_W-1:0] cnt_q;
    logic [2:0][CNT_W-1:0] cnt_d;
    logic [2:0]            rise;
    logic [2:0]            cmd_q;
    logic [2:0]            cmd_d;

    assign raw = {btn_reset_raw, btn_stop_raw, btn_start_raw};

    // Two-flop synchroniser; only sync2_q is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement between the
    // synchronised input and the debounced level. Any single cycle of
    // agreement restarts the count, so short glitches never flip the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int c = 0; c < 3; c++) begin
            if (sync2_q[c] == level_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
                level_d[c] = sync2_q[c];
                cnt_d[c]   = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level, taken from the next-state value so
    // the pulse appears in the same cycle the level first reads 1.
    assign rise = level_d & ~level_q;

    // Fixed priority reset > stop > start; losers are simply discarded.
    always_comb begin
        cmd_d = 3'b000;
        if (rise[2]) begin
            cmd_d = 3'b100;
        end else if (rise[1]) begin
            cmd_d = 3'b010;
        end else if (rise[0]) begin
            cmd_d = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    assign start     = cmd_q[0];
    assign stop      = cmd_q[1];
    assign reset     = cmd_q[2];
    assign btn_level = level_q;

endmodule

// File: tb/tb_button_cmd_gen.sv
module tb_button_cmd_gen;

    localparam int D = 4;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start_raw = 1'b0;
    logic       btn_stop_raw = 1'b0;
    logic       btn_reset_raw = 1'b0;
    logic       start;
    logic       stop;
    logic       reset;
    logic [2:0] btn_level;

    always #5 clk = ~clk;

    button_cmd_gen #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start_raw (btn_start_raw),
        .btn_stop_raw  (btn_stop_raw),
        .btn_reset_raw (btn_reset_raw),
        .start         (start),
        .stop          (stop),
        .reset         (reset),
        .btn_level     (btn_level)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a level flips once the synchronised input (raw delayed
    // by two sampling edges) has disagreed with it on D consecutive edges.
    // The command after an edge is the highest-priority channel that rose.
    // ------------------------------------------------------------------
    logic [2:0] raw_hist[$];
    logic [2:0] seen_hist[$];
    logic [2:0] m_level = 3'b000;
    logic [2:0] m_cmd   = 3'b000;

    function automatic void model_clear();
        raw_hist.delete();
        seen_hist.delete();
        m_level = 3'b000;
        m_cmd   = 3'b000;
    endfunction

    function automatic void model_edge(input logic [2:0] r);
        logic [2:0] seen;
        logic [2:0] old;
        logic [2:0] rose;
        bit         all_diff;
        raw_hist.push_back(r);
        seen = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : 3'b000;
        seen_hist.push_back(seen);
        old = m_level;
        for (int c = 0; c < 3; c++) begin
            if (seen_hist.size() >= D) begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (seen_hist[seen_hist.size()-k][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) m_level[c] = ~m_level[c];
            end
        end
        rose  = m_level & ~old;
        m_cmd = rose[2] ? 3'b100 : rose[1] ? 3'b010 : rose[0] ? 3'b001 : 3'b000;
        while (raw_hist.size() > 8)  void'(raw_hist.pop_front());
        while (seen_hist.size() > 8) void'(seen_hist.pop_front());
    endfunction

    // ------------------------------------------------------------------
    // Driver: apply raw levels, clock one edge, sample 1 time unit later.
    // ------------------------------------------------------------------
    task automatic tick(input logic [2:0] r, output logic [2:0] cmd_out);
        {btn_reset_raw, btn_stop_raw, btn_start_raw} = r;
        @(posedge clk);
        if (!rst_n) model_clear();
        else        model_edge(r);
        #1;
        cmd_out = {reset, stop, start};
        check("cmd_vs_model",   cmd_out,   m_cmd);
        check("level_vs_model", btn_level, m_level);
        check("cmd_onehot0",    32'($onehot0(cmd_out)), 32'd1);
    endtask

    task automatic ticks(input logic [2:0] r, input int n);
        logic [2:0] c;
        for (int i = 0; i < n; i++) tick(r, c);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check("async_rst_cmd",   {reset, stop, start}, 3'b000);
        check("async_rst_level", btn_level, 3'b000);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: clean start press then release, from idle.
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0] raw;
        logic [2:0] cmd;
        logic [2:0] lvl;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [2:0] c;
        int         first;
        int         n_a;
        int         n_b;
        bit         lvl_seen;

        // press: pulse after the 6th sampling edge (E0+5)
        for (int i = 0; i < 8; i++) begin
            vecs[i].raw = 3'b001;
            vecs[i].cmd = (i == 5) ? 3'b001 : 3'b000;
            vecs[i].lvl = (i >= 5) ? 3'b001 : 3'b000;
        end
        // release: level falls after 6th sampling edge, no pulse
        for (int i = 8; i < 14; i++) begin
            vecs[i].raw = 3'b000;
            vecs[i].cmd = 3'b000;
            vecs[i].lvl = (i == 13) ? 3'b000 : 3'b001;
        end

        // Reset state
        #1;
        check("reset_cmd",   {reset, stop, start}, 3'b000);
        check("reset_level", btn_level, 3'b000);
        ticks(3'b000, 3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ticks(3'b000, 4);

        // Table-driven clean press / release
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].raw, c);
            check("vec_cmd",   c,         vecs[i].cmd);
            check("vec_level", btn_level, vecs[i].lvl);
        end
        ticks(3'b000, 4);

        // Bounce on stop, then hold
        n_a = 0;
        for (int i = 0; i < 6; i++) begin
            tick((i % 2 == 0) ? 3'b010 : 3'b000, c);
            if (c != 3'b000) n_a++;
        end
        check("bounce_no_early_pulse", n_a, 0);
        first = -1; n_a = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(3'b010, c);
            if (c[1]) begin
                n_a++;
                if (first < 0) first = i;
            end
        end
        check("bounce_pulse_edge",  first, 6);
        check("bounce_pulse_count", n_a,   1);
        ticks(3'b000, 8);

        // Glitch rejection on reset channel
        n_a = 0; lvl_seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick((i < 3) ? 3'b100 : 3'b000, c);
            if (c[2]) n_a++;
            if (btn_level[2]) lvl_seen = 1'b1;
        end
        check("glitch_no_pulse", n_a, 0);
        check("glitch_no_level", 32'(lvl_seen), 0);

        // Long hold, release, re-press
        n_a = 0;
        for (int i = 0; i < 50; i++) begin
            tick(3'b001, c);
            if (c[0]) n_a++;
        end
        check("hold_one_pulse", n_a, 1);
        ticks(3'b000, 10);
        first = -1; n_a = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(3'b001, c);
            if (c[0]) begin
                n_a++;
                if (first < 0) first = i;
            end
        end
        check("repress_pulse_edge",  first, 6);
        check("repress_pulse_count", n_a,   1);
        ticks(3'b000, 8);

        // Simultaneous press: only reset wins
        n_a = 0; n_b = 0;
        for (int i = 0; i < 12; i++) begin
            tick(3'b111, c);
            if (c[2]) n_a++;
            if (c[1] || c[0]) n_b++;
        end
        check("simul_reset_pulses", n_a, 1);
        check("simul_losers",       n_b, 0);
        check("simul_level",        btn_level, 3'b111);
        ticks(3'b000, 8);

        // Async reset mid-count, button held through release
        ticks(3'b001, 3);
        assert_reset();
        ticks(3'b001, 2);
        rst_n = 1'b1;
        first = -1; n_a = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(3'b001, c);
            if (c[0]) begin
                n_a++;
                if (first < 0) first = i;
            end
        end
        check("rst_hold_pulse_edge",  first, 6);
        check("rst_hold_pulse_count", n_a,   1);

        // Async reset on a pulse cycle
        ticks(3'b000, 8);
        ticks(3'b001, 5);
        tick(3'b001, c);
        check("pulse_before_rst", c, 3'b001);
        assert_reset();
        ticks(3'b000, 2);
        rst_n = 1'b1;
        ticks(3'b000, 6);

        // Randomised segments against the model
        for (int seg = 0; seg < 90; seg++) begin
            ticks(3'($urandom_range(0, 7)), $urandom_range(1, 9));
            if ($urandom_range(0, 24) == 0) begin
                assert_reset();
                ticks(3'($urandom_range(0, 7)), $urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
